// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants for the instruction-fetch stage
// Contents: FSM state encodings, the NOP instruction word and the PC
// increment that the external PC+4 Adder has tied to its second input.
package fetch_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_FAULT = 2'd2;

  localparam logic [31:0] NOP    = 32'h0000_0000;
  localparam logic [31:0] PC_INC = 32'd4;

endpackage

// File: rtl/pc_register.sv
// rtl/pc_register.sv - 32-bit program-counter register with load enable
// Ports:
//   clk   in   1   rising-edge clock
//   rst_n in   1   asynchronous active-low reset, loads RESET_PC
//   load  in   1   capture din on the next rising edge
//   din   in  32   next PC value
//   q     out 32   current PC value
module pc_register #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] din,
  output logic [31:0] q
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign q = pc_q;

endmodule

// File: rtl/pc_fetch_stage.sv
// rtl/pc_fetch_stage.sv - MIPS instruction-fetch stage: PC, imem handshake, IF/ID register
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned redirect -> FAULT, adds FetchFault)
// Ports:
//   Clk          in   1   rising-edge clock
//   Rst          in   1   asynchronous active-low reset
//   PCAddResult  in  32   PCOut+4 from the external Adder (sequential next PC)
//   BranchTarget in  32   branch target, taken when PCSrc=1
//   PCSrc        in   1   take branch this cycle
//   JumpTarget   in  32   jump target, taken when Jump=1 (wins over PCSrc)
//   Jump         in   1   take jump this cycle
//   Stall        in   1   hold PC and IF/ID
//   Flush        in   1   squash IF/ID
//   ImemReady    in   1   imem accepts the request and returns data this cycle
//   ImemData     in  32   instruction word, valid when ImemReq && ImemReady
//   PCOut        out 32   current PC (Adder input and imem address)
//   ImemReq      out  1   fetch request
//   IFID_Instr   out 32   registered instruction
//   IFID_PC4     out 32   registered PC+4 of that instruction
//   IFID_Valid   out  1   IF/ID holds a real instruction
//   FetchFault   out  1   (macro only) stage is parked in FAULT
module pc_fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] PCAddResult,
  input  logic [31:0] BranchTarget,
  input  logic        PCSrc,
  input  logic [31:0] JumpTarget,
  input  logic        Jump,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        ImemReady,
  input  logic [31:0] ImemData,
  output logic [31:0] PCOut,
  output logic        ImemReq,
  output logic [31:0] IFID_Instr,
  output logic [31:0] IFID_PC4,
  output logic        IFID_Valid
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        FetchFault
`endif
);

  logic [1:0]  state_q, state_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic        ifid_valid_q, ifid_valid_d;

  logic        pc_load;
  logic [31:0] pc_next;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        fetch_done;

  // Request is withheld while stalled, so a response can never arrive
  // that the stage is unable to accept; no response buffer is needed.
  assign ImemReq         = (state_q == S_FETCH) && !Stall;
  assign fetch_done      = ImemReq && ImemReady;
  assign redirect        = Jump || PCSrc;
  assign redirect_target = Jump ? JumpTarget : BranchTarget;

  always_comb begin
    state_d      = state_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_valid_d = ifid_valid_q;
    pc_load      = 1'b0;
    pc_next      = PCAddResult;

    case (state_q)
      S_IDLE: begin
        state_d      = S_FETCH;
        ifid_valid_d = 1'b0;
        ifid_instr_d = NOP_INSTR;
      end
      S_FETCH: begin
        if (redirect) begin
          // Overrides stall and discards any coincident imem response.
          pc_load      = 1'b1;
          pc_next      = redirect_target;
          ifid_valid_d = 1'b0;
          ifid_instr_d = NOP_INSTR;
`ifdef FETCH_MISALIGN_TRAP_EN
          if (redirect_target[1:0] != 2'b00) begin
            state_d = S_FAULT;
          end
`endif
        end else if (Flush) begin
          // A completing fetch still advances the PC; its word is dropped.
          pc_load      = fetch_done;
          ifid_valid_d = 1'b0;
          ifid_instr_d = NOP_INSTR;
        end else if (Stall) begin
          pc_load = 1'b0;
        end else if (fetch_done) begin
          pc_load      = 1'b1;
          ifid_instr_d = ImemData;
          ifid_pc4_d   = PCAddResult;
          ifid_valid_d = 1'b1;
        end else begin
          ifid_valid_d = 1'b0;
          ifid_instr_d = NOP_INSTR;
        end
      end
      default: begin
        // FAULT: parked until reset.
        ifid_valid_d = 1'b0;
        ifid_instr_d = NOP_INSTR;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q      <= S_IDLE;
      ifid_instr_q <= NOP_INSTR;
      ifid_pc4_q   <= 32'h0000_0000;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  pc_register #(
    .RESET_PC(RESET_PC)
  ) u_pc_register (
    .clk  (Clk),
    .rst_n(Rst),
    .load (pc_load),
    .din  (pc_next),
    .q    (PCOut)
  );

  assign IFID_Instr = ifid_instr_q;
  assign IFID_PC4   = ifid_pc4_q;
  assign IFID_Valid = ifid_valid_q;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign FetchFault = (state_q == S_FAULT);
`endif

endmodule

// File: doc/pc_fetch_stage.md
Name: pc_fetch_stage

Overview:
- Instruction-fetch stage of the 32-bit MIPS datapath. Sits directly upstream of the PC+4 Adder.
- Owns the program-counter register and drives PCOut into the Adder's first input; the Adder's second input is tied to 4.
- Consumes the Adder's sum (PCAddResult) as the sequential next PC.
- Performs a req/ready handshake with instruction memory, applies branch/jump redirects, and loads the IF/ID pipeline register with stall and flush support.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction injected into IF/ID on a bubble or flush.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Rst  in  1  asynchronous, active-low reset.
- PCAddResult  in  32  PCOut+4 from the Adder.
- BranchTarget  in  32  branch target address.
- PCSrc  in  1  take branch this cycle.
- JumpTarget  in  32  jump target address.
- Jump  in  1  take jump this cycle.
- Stall  in  1  hazard unit: hold PC and IF/ID.
- Flush  in  1  squash IF/ID contents.
- ImemReady  in  1  instruction memory accepts the request and returns data this cycle.
- ImemData  in  32  instruction word, valid when ImemReq&&ImemReady.
- PCOut  out  32  current PC; goes to the Adder input and the imem address.
- ImemReq  out  1  fetch request.
- IFID_Instr  out  32  registered instruction.
- IFID_PC4  out  32  registered PC+4 of that instruction.
- IFID_Valid  out  1  IF/ID holds a real instruction.

Behaviour:
- Reset (Rst=0, asynchronous):
  - PCOut=RESET_PC, state=IDLE, ImemReq=0.
  - IFID_Instr=NOP_INSTR, IFID_PC4=0, IFID_Valid=0.
  - Rst deasserted mid-fetch: any outstanding request is abandoned, with no residue.
- States:
  - IDLE: one cycle after reset release, ImemReq=0, IFID_Valid=0, then unconditionally -> FETCH.
  - FETCH: steady state.
  - FAULT: only with the optional feature.
- ImemReq = (state==FETCH) && !Stall. It is combinational and never asserted while stalled, so no response buffer is needed.
- Redirect = Jump || PCSrc. Jump has priority: the target is JumpTarget if Jump, else BranchTarget.
- Per-cycle priority in FETCH, highest first:
  1. Redirect: PC<=target; IFID_Valid<=0; IFID_Instr<=NOP_INSTR. This applies even if Stall=1 or ImemReady=1 in the same cycle; a coincident response is discarded.
  2. Flush (no redirect): IFID_Valid<=0, IFID_Instr<=NOP_INSTR; PC advances only if a fetch completes this cycle, with the instruction dropped.
  3. Stall: PC and all IF/ID registers hold.
  4. Fetch complete (ImemReq&&ImemReady): PC<=PCAddResult; IFID_Instr<=ImemData; IFID_PC4<=PCAddResult; IFID_Valid<=1.
  5. Wait (ImemReq&&!ImemReady): PC holds; IFID_Valid<=0, IFID_Instr<=NOP_INSTR (bubble).
- Latency:
  - Zero-wait memory gives one instruction per cycle.
  - The instruction at PC appears on IFID_* one edge after the cycle its handshake completes.
  - First valid IF/ID occurs 2 cycles after reset release.
- Arithmetic:
  - No internal adder; PC increment is taken from PCAddResult only.
  - Wrap 32'hFFFF_FFFC -> 0 is the Adder's modulo-2^32 result and is accepted as-is.
- IFID_PC4 holds its last value when IFID_Valid=0 (don't-care to downstream).

Optional Feature:
- Macro FETCH_MISALIGN_TRAP_EN.
- Defined:
  - If a taken redirect target has [1:0]!=2'b00, go to FAULT and keep PCOut at the offending target.
  - In FAULT, ImemReq=0 and IFID_Valid=0 permanently; only Rst exits.
  - Adds output FetchFault (1 bit, 1 in FAULT, reset 0).
- Undefined: targets load unchecked, there is no FAULT state, and no FetchFault port exists.

Decomposition:
- Shared package fetch_pkg:
  - State encoding constants S_IDLE=2'd0, S_FETCH=2'd1, S_FAULT=2'd2.
  - NOP constant 32'h0000_0000.
  - PC_INC=4, used by the Adder tie-off.
- One sub-module, pc_register: 32-bit register with async active-low reset to RESET_PC, load-enable and data-in; instantiated for PCOut.

Test Plan:
- Reset then zero-wait memory (ImemReady=1), external Adder closed loop -> PCOut 0,4,8,12 on successive cycles; first IFID_Valid=1 with IFID_PC4=4 two cycles after Rst rises.
- ImemReady low 3 cycles at PC=8 -> PCOut holds 8; IFID_Valid=0 for 3 cycles; then IFID_PC4=12 with the correct ImemData.
- Stall=1 for 2 cycles at PC=16 -> ImemReq=0, PCOut=16, IF/ID unchanged; resumes at 16.
- Jump=1 (JumpTarget=0x100) and PCSrc=1 (BranchTarget=0x40) with ImemReady=1 in the same cycle -> PCOut=0x100, IFID_Valid=0, response dropped; next IFID_PC4=0x104.
- Stall=1 and PCSrc=1 (BranchTarget=0x80) together -> PCOut=0x80, IFID flushed to NOP.
- With FETCH_MISALIGN_TRAP_EN: Jump to 0x102 -> FetchFault=1, ImemReq=0 until Rst; without the macro -> PCOut=0x102 and fetching continues.
